// File: rtl/elevator_pkg.sv
// Shared types and helpers for the elevator car controller and its display path.
//   state_t     : car FSM states
//   NUM_FLOORS  : number of served floors (0..6)
//   POS_W       : width of the car position register
//   therm()     : position -> thermometer floor vector (bits[pos-1:0] set)
//   onehot()    : position -> single-bit floor mask
//   above_mask(): floors strictly above a position
package elevator_pkg;

    localparam int unsigned NUM_FLOORS = 7;
    localparam int unsigned POS_W      = 3;
    localparam logic [POS_W-1:0] MAX_POS = 3'd6;

    typedef enum logic [1:0] {
        st_idle,
        st_move_up,
        st_move_down,
        st_door_open
    } state_t;

    function automatic logic [NUM_FLOORS-1:0] therm(input logic [POS_W-1:0] pos);
        return 7'((8'd1 << pos) - 8'd1);
    endfunction

    function automatic logic [NUM_FLOORS-1:0] onehot(input logic [POS_W-1:0] pos);
        return 7'(8'd1 << pos);
    endfunction

    function automatic logic [NUM_FLOORS-1:0] above_mask(input logic [POS_W-1:0] pos);
        return ~(therm(pos) | onehot(pos));
    endfunction

endpackage

// File: rtl/tick_timer.sv
// Loadable down-counter used for both travel and door timing.
//   clk, reset : clock and asynchronous active-low reset
//   load       : load load_val this cycle (wins over counting)
//   load_val   : value to load
//   tick       : count enable; counter decrements on tick while nonzero
//   zero       : counter currently holds zero
module tick_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             tick,
    output logic             zero
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (tick && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/elevator_car_ctrl.sv
// Car-motion controller for a 7-floor elevator. Latches floor calls, moves the car one
// floor per travel period and holds the door open at each served floor.
//   clk       : system clock
//   reset     : asynchronous active-low reset (homes the car to floor 0)
//   tick      : slow timing enable from the board divider
//   call      : floor request buttons, bit k = floor k
//   floor     : thermometer-coded car position for the HEX display stage
//   pending   : latched, unserved requests
//   door_open : car is standing with the door open
//   dir_up    : car is moving up
//   dir_down  : car is moving down
module elevator_car_ctrl
    import elevator_pkg::*;
#(
    parameter int unsigned TRAVEL_TICKS = 2,
    parameter int unsigned DOOR_TICKS   = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick,
    input  logic [NUM_FLOORS-1:0] call,
    output logic [NUM_FLOORS-1:0] floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  door_open,
    output logic                  dir_up,
    output logic                  dir_down
);

    localparam int unsigned TIMER_W = 8;
    localparam logic [TIMER_W-1:0] TRAVEL_VAL = TIMER_W'(TRAVEL_TICKS - 1);
    localparam logic [TIMER_W-1:0] DOOR_VAL   = TIMER_W'(DOOR_TICKS - 1);

    state_t                state_q, state_d;
    logic [POS_W-1:0]      pos_q, pos_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic                  last_up_q, last_up_d;

    logic                  t_load;
    logic [TIMER_W-1:0]    t_val;
    logic                  t_zero;
    logic [NUM_FLOORS-1:0] clr;
    logic [POS_W-1:0]      step_pos;
    logic                  req_above, req_below;

    tick_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (t_load),
        .load_val (t_val),
        .tick     (tick),
        .zero     (t_zero)
    );

    assign req_above = |(pending_q & above_mask(pos_q));
    assign req_below = |(pending_q & therm(pos_q));

    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        last_up_d = last_up_q;
        t_load    = 1'b0;
        t_val     = '0;
        clr       = '0;
        step_pos  = pos_q;

        unique case (state_q)
            st_idle: begin
                if (pending_q[pos_q]) begin
                    state_d = st_door_open;
                    t_load  = 1'b1;
                    t_val   = DOOR_VAL;
                    clr     = onehot(pos_q);
                end else if (req_above) begin
                    state_d   = st_move_up;
                    t_load    = 1'b1;
                    t_val     = TRAVEL_VAL;
                    last_up_d = 1'b1;
                end else if (req_below) begin
                    state_d   = st_move_down;
                    t_load    = 1'b1;
                    t_val     = TRAVEL_VAL;
                    last_up_d = 1'b0;
                end
            end

            st_move_up, st_move_down: begin
                if (tick && t_zero) begin
                    step_pos = (state_q == st_move_up) ? pos_q + 3'd1 : pos_q - 3'd1;
                    pos_d    = step_pos;
                    if (pending_q[step_pos]) begin
                        state_d = st_door_open;
                        t_load  = 1'b1;
                        t_val   = DOOR_VAL;
                        // Clear the arrival floor on the entry cycle so a stale bit never
                        // survives into the door period.
                        clr     = onehot(step_pos);
                    end else if ((state_q == st_move_up)
                                 ? |(pending_q & above_mask(step_pos))
                                 : |(pending_q & therm(step_pos))) begin
                        t_load = 1'b1;
                        t_val  = TRAVEL_VAL;
                    end else begin
                        state_d = st_idle;
                    end
                end
            end

            st_door_open: begin
                // Calls for the current floor are swallowed while the door is open.
                clr = onehot(pos_q);
                if (call[pos_q]) begin
                    t_load = 1'b1;
                    t_val  = DOOR_VAL;
                end else if (tick && t_zero) begin
                    t_load = 1'b1;
                    t_val  = TRAVEL_VAL;
                    // Prefer continuing in the last direction of travel.
                    if (last_up_q) begin
                        if (req_above) begin
                            state_d = st_move_up;
                        end else if (req_below) begin
                            state_d   = st_move_down;
                            last_up_d = 1'b0;
                        end else begin
                            state_d = st_idle;
                        end
                    end else begin
                        if (req_below) begin
                            state_d = st_move_down;
                        end else if (req_above) begin
                            state_d   = st_move_up;
                            last_up_d = 1'b1;
                        end else begin
                            state_d = st_idle;
                        end
                    end
                end
            end

            default: state_d = st_idle;
        endcase

        pending_d = (pending_q | call) & ~clr;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= st_idle;
            pos_q     <= '0;
            pending_q <= '0;
            last_up_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            pending_q <= pending_d;
            last_up_q <= last_up_d;
        end
    end

    pos_in_range: assert property (@(posedge clk) disable iff (!reset) pos_d <= MAX_POS);

    assign floor     = therm(pos_q);
    assign pending   = pending_q;
    assign door_open = (state_q == st_door_open);
    assign dir_up    = (state_q == st_move_up);
    assign dir_down  = (state_q == st_move_down);

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// Directed bench for elevator_car_ctrl with TRAVEL_TICKS=2, DOOR_TICKS=3.
module tb_elevator_car_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b1;
    logic [6:0] call = '0;
    logic [6:0] floor;
    logic [6:0] pending;
    logic       door_open;
    logic       dir_up;
    logic       dir_down;

    int total = 0;
    int bad = 0;

    elevator_car_ctrl #(
        .TRAVEL_TICKS (2),
        .DOOR_TICKS   (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .call      (call),
        .floor     (floor),
        .pending   (pending),
        .door_open (door_open),
        .dir_up    (dir_up),
        .dir_down  (dir_down)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
        total++;
        assert (got === want)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, want);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [7:0] exp_floor(input int p);
        logic [7:0] v;
        v = '0;
        for (int k = 0; k < p; k++) v[k] = 1'b1;
        return v;
    endfunction

    initial begin
        // Reset state
        #3;
        check("rst_floor", {1'b0, floor}, 8'h00);
        check("rst_pending", {1'b0, pending}, 8'h00);
        check("rst_outs", {5'b0, door_open, dir_up, dir_down}, 8'h00);
        reset = 1'b1;

        // 1: single call to floor 3
        call = 7'h08;
        step(1);
        call = '0;
        check("t1_latch", {1'b0, pending}, 8'h08);
        check("t1_not_moving", {7'b0, dir_up}, 8'h00);
        step(1);
        check("t1_dir_up", {7'b0, dir_up}, 8'h01);
        check("t1_floor0", {1'b0, floor}, 8'h00);
        step(2);
        check("t1_floor1", {1'b0, floor}, 8'h01);
        step(2);
        check("t1_floor2", {1'b0, floor}, 8'h03);
        step(2);
        check("t1_floor3", {1'b0, floor}, 8'h07);
        check("t1_door", {6'b0, door_open, dir_up}, 8'h02);
        check("t1_served", {1'b0, pending}, 8'h00);
        step(2);
        check("t1_door_held", {7'b0, door_open}, 8'h01);
        step(1);
        check("t1_idle", {5'b0, door_open, dir_up, dir_down}, 8'h00);

        // 2: call at the current floor (fresh reset, floor 0)
        reset = 1'b0;
        #1;
        reset = 1'b1;
        call = 7'h01;
        step(1);
        call = '0;
        check("t2_latch", {1'b0, pending}, 8'h01);
        check("t2_door_closed", {7'b0, door_open}, 8'h00);
        step(1);
        check("t2_door", {7'b0, door_open}, 8'h01);
        check("t2_pending", {1'b0, pending}, 8'h00);
        step(3);
        check("t2_idle", {7'b0, door_open}, 8'h00);

        // 3: stop at 5 while going up, then reverse to 1
        call = 7'h20;
        step(1);
        call = '0;
        step(7);
        check("t3_at3", {1'b0, floor}, 8'h07);
        check("t3_up", {7'b0, dir_up}, 8'h01);
        call = 7'h02;
        step(1);
        call = '0;
        check("t3_pending", {1'b0, pending}, 8'h22);
        step(3);
        check("t3_floor5", {1'b0, floor}, 8'h1f);
        check("t3_door5", {7'b0, door_open}, 8'h01);
        check("t3_pending5", {1'b0, pending}, 8'h02);
        step(3);
        check("t3_down", {6'b0, door_open, dir_down}, 8'h01);
        step(4);
        check("t3_at3_down", {1'b0, floor}, 8'h07);
        check("t3_still_down", {7'b0, dir_down}, 8'h01);
        step(4);
        check("t3_floor1", {1'b0, floor}, 8'h01);
        check("t3_door1", {7'b0, door_open}, 8'h01);
        check("t3_served", {1'b0, pending}, 8'h00);
        step(3);
        check("t3_idle", {7'b0, door_open}, 8'h00);

        // 4: door held by call at floor 2
        call = 7'h04;
        step(1);
        call = '0;
        step(3);
        check("t4_door2", {7'b0, door_open}, 8'h01);
        check("t4_floor2", {1'b0, floor}, 8'h03);
        call = 7'h04;
        step(4);
        call = '0;
        check("t4_held", {7'b0, door_open}, 8'h01);
        check("t4_not_latched", {1'b0, pending}, 8'h00);
        step(2);
        check("t4_still_open", {7'b0, door_open}, 8'h01);
        step(1);
        check("t4_closed", {7'b0, door_open}, 8'h00);

        // 5: asynchronous reset during upward motion
        call = 7'h40;
        step(1);
        call = '0;
        step(1);
        check("t5_moving", {7'b0, dir_up}, 8'h01);
        #2;
        reset = 1'b0;
        #1;
        check("t5_floor", {1'b0, floor}, 8'h00);
        check("t5_pending", {1'b0, pending}, 8'h00);
        check("t5_outs", {5'b0, door_open, dir_up, dir_down}, 8'h00);
        reset = 1'b1;

        // 6: top floor with a sparse tick; position advances every 8th edge
        for (int i = 0; i < 56; i++) begin
            tick = (i % 4 == 0);
            call = (i == 0) ? 7'h40 : 7'h00;
            step(1);
            check("t6_floor", {1'b0, floor}, exp_floor((i / 8 > 6) ? 6 : i / 8));
        end
        call = '0;
        tick = 1'b1;
        check("t6_top", {1'b0, floor}, 8'h3f);
        check("t6_door", {7'b0, door_open}, 8'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
